// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for the Banff core.
// Owns the program counter, issues sequential word fetches to instruction
// memory, buffers responses in an in-order queue and presents them to decode
// over a valid/ready handshake. Redirects flush the queue, restart fetch and
// discard responses still in flight.
//
// Ports:
//   clock, reset (async, active-low)
//   redirect_valid / redirect_pc      : flush and restart fetch at redirect_pc
//   imem_req_valid / _addr / _ready   : fetch request channel
//   imem_resp_valid / _data / _err    : in-order response channel, never stalled
//   dec_valid / _instr / _pc / _fault : head entry presented to decode
//   dec_ready                         : decode accepts the head entry
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_fault,
  input  logic        dec_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [CW:0] DEPTH_S = (CW + 1)'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic          req_valid_q, req_valid_d;

  logic [31:0]   ent_pc_q    [DEPTH];
  logic [31:0]   ent_instr_q [DEPTH];
  logic          ent_fault_q [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic [AW:0]   occupancy;
  logic [AW:0]   occupancy_d;
  logic [CW:0]   credit_sum;
  logic [31:0]   push_instr;
  logic [31:0]   redirect_pc_aligned;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_pc_aligned  = {redirect_pc[31:2], 2'b00};

  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign accept     = req_valid_q & imem_req_ready;
  assign dec_valid  = (occupancy != '0);
  assign pop        = dec_valid & dec_ready;
  // A response is kept only when no redirect is dropping it this cycle and
  // no earlier redirect left it marked as stale.
  assign push       = imem_resp_valid & ~redirect_valid & (stale_q == '0);
  assign push_instr = imem_resp_err ? '0 : imem_resp_data;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    stale_d       = stale_q;
    rd_ptr_d      = rd_ptr_q + (AW + 1)'(pop);
    wr_ptr_d      = wr_ptr_q + (AW + 1)'(push);
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_resp_valid);

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_resp_valid && (stale_q != '0)) begin
      stale_d = stale_q - CW'(1);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      if (imem_resp_err) begin
        state_d = HALT;
      end
    end

    // Everything still in flight after this edge, including a request
    // accepted right now, belongs to the old stream and must be discarded.
    if (redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      stale_d    = outstanding_d;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end

    // Request valid is registered from next-state counts so the request
    // channel carries no combinational path from any input.
    occupancy_d = wr_ptr_d - rd_ptr_d;
    credit_sum  = {1'b0, occupancy_d} + {1'b0, outstanding_d};
    req_valid_d = (state_d == RUN) && (credit_sum < DEPTH_S);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      req_valid_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
        ent_fault_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      req_valid_q   <= req_valid_d;
      if (push) begin
        ent_pc_q[wr_ptr_q[AW-1:0]]    <= resp_pc_q;
        ent_instr_q[wr_ptr_q[AW-1:0]] <= push_instr;
        ent_fault_q[wr_ptr_q[AW-1:0]] <= imem_resp_err;
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;

  assign dec_pc    = dec_valid ? ent_pc_q[rd_ptr_q[AW-1:0]]    : '0;
  assign dec_instr = dec_valid ? ent_instr_q[rd_ptr_q[AW-1:0]] : '0;
  assign dec_fault = dec_valid ? ent_fault_q[rd_ptr_q[AW-1:0]] : 1'b0;

  // The credit rule bounds buffered plus in-flight entries, so a push into a
  // full queue without a matching pop indicates a broken credit calculation.
  assert property (@(posedge clock) disable iff (!reset)
    (push && !pop) |-> (occupancy != DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;
  logic        dec_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .dec_valid       (dec_valid),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_fault       (dec_fault),
    .dec_ready       (dec_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory-side view: every accepted request with the stream (epoch) it
  // belongs to and the edge its response is due.
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  // Decode-side view: entries the front end should be presenting, in order.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  req_t        pending[$];
  ent_t        mq[$];
  int unsigned epoch;
  int unsigned edge_n;
  int unsigned last_due;
  logic [31:0] exp_fetch;
  bit          halted;

  int unsigned p_ready, p_dec, p_redir, min_lat, max_lat;
  bit          err_en;
  logic [31:0] err_addr;
  bit          force_redir;
  logic [31:0] force_pc;

  int n_checks;
  int n_errors;
  int acc_cnt;
  int pop_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_fault", 32'(dec_fault), 32'd0);
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = !halted && ((mq.size() + pending.size()) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
    chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
    if (dec_valid && mq.size() != 0) begin
      chk("dec_pc", dec_pc, mq[0].pc);
      chk("dec_instr", dec_instr, mq[0].instr);
      chk("dec_fault", 32'(dec_fault), 32'(mq[0].fault));
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the reference model
  // by the events of the active edge. Entered and left on a falling edge.
  task automatic step();
    req_t        r;
    int unsigned lat;
    int unsigned due;
    bit          c_accept, c_pop, c_redir, c_resp, c_err;
    logic [31:0] c_redir_pc;

    check_outputs();

    c_redir = force_redir || ($urandom_range(999) < p_redir);
    if (force_redir) c_redir_pc = force_pc;
    else if ($urandom_range(3) == 0) c_redir_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
    else c_redir_pc = $urandom;
    force_redir = 1'b0;
    redirect_valid = c_redir;
    redirect_pc    = c_redir_pc;
    imem_req_ready = ($urandom_range(99) < p_ready);
    dec_ready      = ($urandom_range(99) < p_dec);

    c_resp = (pending.size() != 0) && (pending[0].due <= edge_n + 1);
    c_err  = 1'b0;
    if (c_resp) begin
      c_err = err_en && (pending[0].addr == err_addr);
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pending[0].addr);
      imem_resp_err   = c_err;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom);
    end

    c_accept = imem_req_valid && imem_req_ready;
    c_pop    = dec_valid && dec_ready;

    @(posedge clock);
    edge_n++;
    if (c_pop && mq.size() != 0) begin
      void'(mq.pop_front());
      pop_cnt++;
    end
    if (c_resp) begin
      r = pending.pop_front();
      if (!c_redir && r.epoch == epoch) begin
        mq.push_back('{pc: r.addr, instr: (c_err ? 32'd0 : mem_word(r.addr)), fault: c_err});
        if (c_err) halted = 1'b1;
      end
    end
    if (c_accept) begin
      lat = $urandom_range(max_lat, min_lat);
      due = edge_n + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{addr: exp_fetch, epoch: epoch, due: due});
      exp_fetch = exp_fetch + 32'd4;
      acc_cnt++;
    end
    if (c_redir) begin
      mq.delete();
      epoch++;
      exp_fetch = {c_redir_pc[31:2], 2'b00};
      halted = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1'b1;
    force_pc = pc;
    step();
  endtask

  task automatic wait_dec(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 50 && !dec_valid; i++) step();
    chk({tag, "_valid"}, 32'(dec_valid), 32'd1);
    if (dec_valid) chk(tag, dec_pc, exp_pc);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    for (int i = 0; i < 50 && !imem_req_valid; i++) step();
    chk({tag, "_valid"}, 32'(imem_req_valid), 32'd1);
    if (imem_req_valid) chk(tag, imem_req_addr, exp_addr);
  endtask

  task automatic stream_knobs(input int unsigned lat);
    p_ready = 100; p_dec = 100; p_redir = 0;
    min_lat = lat; max_lat = lat;
  endtask

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    dec_ready       = 1'b0;
  endtask

  task automatic clear_model();
    pending.delete();
    mq.delete();
    halted = 1'b0;
    exp_fetch = RESET_PC;
    last_due = edge_n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, summary not printed normally");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; acc_cnt = 0; pop_cnt = 0;
    epoch = 0; edge_n = 0; force_redir = 1'b0; force_pc = '0;
    err_en = 1'b0; err_addr = '0;
    stream_knobs(1);
    clear_model();
    reset = 1'b0;
    idle_inputs();

    #1;
    chk_reset_vals();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk_reset_vals();
    @(posedge clock);
    @(negedge clock);

    // Streaming from reset, latency 1: one instruction per cycle after fill.
    repeat (10) step();
    pop_cnt = 0;
    repeat (20) step();
    chk("throughput", 32'(pop_cnt), 32'd20);

    // Decode back-pressure: exactly DEPTH new requests after a redirect.
    p_dec = 0;
    redirect_to(32'h0000_1000);
    acc_cnt = 0;
    repeat (12) step();
    chk("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    p_dec = 100;
    repeat (10) step();

    // Three requests in flight, then redirect; misaligned redirect target.
    stream_knobs(3);
    repeat (10) step();
    redirect_to(32'h0000_0100);
    wait_dec("redir_pc", 32'h0000_0100);
    redirect_to(32'h0000_0203);
    wait_req("redir_align", 32'h0000_0200);
    wait_dec("redir_align_dec", 32'h0000_0200);

    // Access fault at 0x8 halts fetch; redirect resumes.
    stream_knobs(1);
    err_en = 1'b1;
    err_addr = 32'h0000_0008;
    redirect_to(32'h0000_0000);
    for (int i = 0; i < 50 && !(dec_valid && dec_fault); i++) step();
    chk("fault_flag", 32'(dec_fault), 32'd1);
    chk("fault_pc", dec_pc, 32'h0000_0008);
    chk("fault_instr", dec_instr, 32'd0);
    repeat (8) step();
    chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
    err_en = 1'b0;
    redirect_to(32'h0000_0040);
    wait_req("resume_addr", 32'h0000_0040);
    wait_dec("resume_dec", 32'h0000_0040);

    // Redirect coinciding with handshake, response and accept.
    repeat (10) step();
    redirect_to(32'h0000_0300);
    chk("flush_dec_valid", 32'(dec_valid), 32'd0);
    wait_dec("simul_pc", 32'h0000_0300);

    // Address wrap at the top of the address space.
    redirect_to(32'hFFFF_FFF4);
    wait_dec("wrap_first", 32'hFFFF_FFF4);
    for (int i = 0; i < 20 && !(dec_valid && dec_pc == 32'd0); i++) step();
    chk("wrap_dec_pc", dec_pc, 32'd0);
    repeat (5) step();

    // Randomized traffic against the reference model.
    for (int blk = 0; blk < 20; blk++) begin
      p_ready  = $urandom_range(100, 30);
      p_dec    = $urandom_range(100, 20);
      min_lat  = 1;
      max_lat  = $urandom_range(4, 1);
      p_redir  = $urandom_range(40, 0);
      err_en   = ($urandom_range(2) == 0);
      err_addr = exp_fetch + 32'(4 * $urandom_range(12, 0));
      if (p_redir == 0 && err_en) p_redir = 5;
      repeat (200) step();
    end

    // Asynchronous reset mid-operation; memory is quiesced by the bench.
    stream_knobs(2);
    err_en = 1'b0;
    repeat (10) step();
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk_reset_vals();
    clear_model();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk_reset_vals();
    @(posedge clock);
    @(negedge clock);
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the Banff core, and the producer side of the fetch-to-decode interface that the `decoder` consumes. It owns the program counter and issues sequential word fetches to instruction memory. Responses are buffered in a small in-order queue, and each instruction is presented to decode with its PC and fault flag over a valid/ready handshake. Redirects from later stages flush the queue, restart fetch at a new PC, and discard in-flight responses.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- `DEPTH`, 4, queue entries; power of 2, ≥2; also the cap on in-flight plus buffered requests

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  response valid; responses return in request order, ≥1 cycle after acceptance, never stalled
- `imem_resp_data`  in  32  instruction word
- `imem_resp_err`  in  1  access fault for this response
- `dec_valid`  out  1  instruction available to decode
- `dec_instr`  out  32  instruction word (0 when faulted)
- `dec_pc`  out  32  PC of `dec_instr`
- `dec_fault`  out  1  fetch access fault for this entry
- `dec_ready`  in  1  decoder accepts entry

## Operation
- State machine, 2 states:
  - RUN: issue requests.
  - HALT: entered when a non-stale response with `imem_resp_err`=1 is written. No new requests are issued.
  - HALT → RUN only on `redirect_valid`. Reset enters RUN.
- Request issue:
  - `imem_req_valid`=1 in RUN when `occupancy + outstanding < DEPTH`.
  - Accepted when valid && ready; `fetch_pc` then increments by 4, wrapping modulo 2^32.
  - Unaccepted request holds address stable unless a redirect occurs.
- Counters:
  - `outstanding`: +1 on accept, −1 on any response (stale or not).
  - `stale`: count of responses still to be discarded.
  - Both are clog2(DEPTH)+1 bits.
- Response path:
  - If `stale`>0: decrement `stale`, drop the response.
  - Else: push {`resp_pc`, data or 0 if err, err} into the queue, then `resp_pc` += 4.
  - Credit rule guarantees the queue never overflows; overflow is a design error to be asserted in simulation.
- Decode side:
  - Head entry is driven on `dec_*` while `dec_valid`=1.
  - Pop on `dec_valid && dec_ready`.
  - `dec_*` stable while `dec_valid && !dec_ready`.
- Redirect, same cycle as `redirect_valid`:
  - Queue flushed; `fetch_pc`, `resp_pc` ← {`redirect_pc`[31:2], 2'b00}; state ← RUN.
  - `stale` ← `outstanding` + (accept this cycle) − (response this cycle), plus existing stale accounting.
  - The response arriving this cycle is dropped; the request accepted this cycle becomes stale.
- Simultaneous events:
  - Redirect with decode handshake: the entry is consumed by decode, and the remaining entries are flushed.
  - Push and pop in the same cycle on a non-empty queue: occupancy unchanged.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`
  - `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `dec_fault`=0
  - Counters 0, state RUN
- First request: `imem_req_valid`=1 on the first rising edge after `reset` deasserts.
- Response to decode: a response at edge N gives `dec_valid`=1 after edge N (registered queue, no bypass). Redirect at edge N gives `dec_valid`=0 from edge N.
- New PC after redirect: `imem_req_addr`=new PC, with `imem_req_valid` set per the credit rule, after edge N.
- Throughput: one instruction per cycle sustained when memory latency + 1 ≤ `DEPTH` and `dec_ready`=1.
- Reset asserted mid-operation: all state cleared asynchronously. Responses arriving after release are not expected; the bench must quiesce memory.

## Test plan
- Reset release, memory ready every cycle, 1-cycle latency, `dec_ready`=1 → requests 0x0,0x4,0x8,… one per cycle; decode sees matching PCs and data, no bubbles after fill.
- `dec_ready`=0 with `DEPTH`=4 → exactly 4 requests accepted, `imem_req_valid` drops; `dec_*` held stable. Raising `dec_ready` resumes issue one credit per pop.
- 3 requests in flight, redirect to 0x100 → 3 subsequent responses dropped; first decoded entry has `dec_pc`=0x100; redirect to 0x203 fetches 0x200.
- Response with `imem_resp_err`=1 at PC 0x8 → entry `dec_fault`=1, `dec_instr`=0, no further requests; redirect to 0x40 resumes at 0x40.
- Redirect in the same cycle as a decode handshake, a response, and a request accept → the handshaken entry is consumed; the response and the accepted request are both discarded; the next decoded PC is the redirect target.
- `fetch_pc` at 0xFFFF_FFFC → next request address 0x0000_0000; `dec_pc` wraps identically.
